// File: rtl/matrix_pkg.sv
// matrix_pkg: shared constants for the matrix accelerator datapath.
//   MAC_DATA_W / MAC_CNT_W : default operand/accumulator and term-counter widths
//   SMAX / SMIN            : signed limits at the default data width
//   sat_mode_e             : encoding of the SATURATE parameter (wrap vs clamp)
package matrix_pkg;
    localparam int MAC_DATA_W = 32;
    localparam int MAC_CNT_W  = 8;

    localparam logic [MAC_DATA_W-1:0] SMAX = {1'b0, {(MAC_DATA_W-1){1'b1}}};
    localparam logic [MAC_DATA_W-1:0] SMIN = {1'b1, {(MAC_DATA_W-1){1'b0}}};

    typedef enum int {
        SAT_WRAP  = 0,
        SAT_CLAMP = 1
    } sat_mode_e;
endpackage

// File: rtl/matrix_sat_add.sv
// matrix_sat_add: combinational signed adder with overflow flag and optional clamp.
//   i_x, i_y : signed DATA_W operands
//   o_sum    : i_x + i_y, wrapped or clamped to the signed range (CLAMP)
//   o_ovf    : signed overflow of the raw sum
module matrix_sat_add #(
    parameter int DATA_W = 32,
    parameter bit CLAMP  = 1'b0
) (
    input  logic [DATA_W-1:0] i_x,
    input  logic [DATA_W-1:0] i_y,
    output logic [DATA_W-1:0] o_sum,
    output logic              o_ovf
);
    localparam logic [DATA_W-1:0] S_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] S_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    logic [DATA_W-1:0] raw;

    always_comb begin
        raw   = i_x + i_y;
        // Same-sign operands producing an opposite-sign result.
        o_ovf = (i_x[DATA_W-1] == i_y[DATA_W-1]) && (raw[DATA_W-1] != i_x[DATA_W-1]);
        o_sum = raw;
        // On overflow the operand sign tells which rail was crossed.
        if (CLAMP && o_ovf) begin
            o_sum = i_x[DATA_W-1] ? S_MIN : S_MAX;
        end
    end
endmodule

// File: rtl/matrix_mac_pipe.sv
// matrix_mac_pipe: two-stage pipelined signed multiply-accumulate.
//   i_wb_clk  : clock, posedge
//   m_rst_t   : async active-high reset, clears the whole pipe
//   i_run     : operand pair valid this cycle (always accepted)
//   i_a, i_b  : signed operands
//   o_acc     : registered running sum
//   o_busy    : a term is in stage 1 or stage 2
//   o_count   : terms accumulated since reset, saturating
//   o_ovf     : sticky product/sum overflow
module matrix_mac_pipe
    import matrix_pkg::*;
#(
    parameter int DATA_W   = MAC_DATA_W,
    parameter int CNT_W    = MAC_CNT_W,
    parameter int SATURATE = 0
) (
    input  logic              i_wb_clk,
    input  logic              m_rst_t,
    input  logic              i_run,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_acc,
    output logic              o_busy,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_ovf
);
    localparam bit CLAMP = (SATURATE == int'(SAT_CLAMP));
    localparam logic [DATA_W-1:0] S_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] S_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    // vld_q[0] = stage-1 valid, vld_q[1] = stage-2 updated last cycle
    logic [1:0]        vld_q, vld_d;
    logic [DATA_W-1:0] p1_q, p1_d;
    logic              ovf1_q, ovf1_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;

    logic [2*DATA_W-1:0] prod_full;
    logic                prod_ovf;
    logic [DATA_W-1:0]   prod_red;
    logic [DATA_W-1:0]   sum;
    logic                add_ovf;

    matrix_sat_add #(.DATA_W(DATA_W), .CLAMP(CLAMP)) u_add (
        .i_x   (acc_q),
        .i_y   (p1_q),
        .o_sum (sum),
        .o_ovf (add_ovf)
    );

    always_comb begin
        // Sign-extend to 2*DATA_W so the low bits of the unsigned product
        // are exactly the signed product.
        prod_full = {{DATA_W{i_a[DATA_W-1]}}, i_a} * {{DATA_W{i_b[DATA_W-1]}}, i_b};
        // Fits in DATA_W only if the top DATA_W+1 bits are all equal.
        prod_ovf  = ~(&prod_full[2*DATA_W-1:DATA_W-1]) & (|prod_full[2*DATA_W-1:DATA_W-1]);
        prod_red  = prod_full[DATA_W-1:0];
        if (CLAMP && prod_ovf) begin
            prod_red = prod_full[2*DATA_W-1] ? S_MIN : S_MAX;
        end

        vld_d  = {vld_q[0], i_run};
        p1_d   = i_run ? prod_red : p1_q;
        ovf1_d = i_run ? prod_ovf : ovf1_q;

        acc_d = acc_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (vld_q[0]) begin
            acc_d = sum;
            cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
            ovf_d = ovf_q | ovf1_q | add_ovf;
        end
    end

    always_ff @(posedge i_wb_clk or posedge m_rst_t) begin
        if (m_rst_t) begin
            vld_q  <= '0;
            p1_q   <= '0;
            ovf1_q <= 1'b0;
            acc_q  <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            vld_q  <= vld_d;
            p1_q   <= p1_d;
            ovf1_q <= ovf1_d;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
        end
    end

    assign o_acc   = acc_q;
    assign o_count = cnt_q;
    assign o_ovf   = ovf_q;
    assign o_busy  = |vld_q;
endmodule

// File: tb/tb_matrix_mac_pipe.sv
// tb_matrix_mac_pipe: directed vectors driven into a wrapping and a clamping
// instance side by side; expected values are hand-computed constants.
module tb_matrix_mac_pipe;
    import matrix_pkg::*;

    logic        i_wb_clk = 1'b0;
    logic        m_rst_t  = 1'b0;
    logic        i_run    = 1'b0;
    logic [31:0] i_a      = '0;
    logic [31:0] i_b      = '0;

    logic [31:0] w_acc, s_acc;
    logic [7:0]  w_cnt, s_cnt;
    logic        w_busy, s_busy, w_ovf, s_ovf;

    int checks = 0;
    int fails  = 0;

    always #5 i_wb_clk = ~i_wb_clk;

    matrix_mac_pipe #(.DATA_W(32), .CNT_W(8), .SATURATE(0)) u_wrap (
        .i_wb_clk (i_wb_clk), .m_rst_t (m_rst_t), .i_run (i_run),
        .i_a (i_a), .i_b (i_b),
        .o_acc (w_acc), .o_busy (w_busy), .o_count (w_cnt), .o_ovf (w_ovf)
    );

    matrix_mac_pipe #(.DATA_W(32), .CNT_W(8), .SATURATE(1)) u_sat (
        .i_wb_clk (i_wb_clk), .m_rst_t (m_rst_t), .i_run (i_run),
        .i_a (i_a), .i_b (i_b),
        .o_acc (s_acc), .o_busy (s_busy), .o_count (s_cnt), .o_ovf (s_ovf)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Present one cycle of input, then sample 1 time unit after the edge.
    task automatic step(input logic run, input logic [31:0] a, input logic [31:0] b);
        i_run = run;
        i_a   = a;
        i_b   = b;
        @(posedge i_wb_clk);
        #1;
    endtask

    task automatic do_reset();
        i_run   = 1'b0;
        m_rst_t = 1'b1;
        #2;
        m_rst_t = 1'b0;
    endtask

    initial begin
        // Power-on reset
        #1 m_rst_t = 1'b1;
        #2;
        chk("rst_acc",  w_acc,  0);
        chk("rst_cnt",  w_cnt,  0);
        chk("rst_busy", w_busy, 0);
        chk("rst_ovf",  s_ovf,  0);
        #5 m_rst_t = 1'b0;

        // Single term 3*4, latency 2
        step(1'b1, 32'd3, 32'd4);
        chk("t1_busy_s1", w_busy, 1);
        chk("t1_acc_s1",  w_acc,  0);
        step(1'b0, 32'd0, 32'd0);
        chk("t1_acc",     w_acc,  12);
        chk("t1_cnt",     w_cnt,  1);
        chk("t1_busy_s2", w_busy, 1);
        step(1'b0, 32'd0, 32'd0);
        chk("t1_busy_off", w_busy, 0);

        // Stream 1..8 times 2
        do_reset();
        for (int k = 1; k <= 8; k++) step(1'b1, 32'(k), 32'd2);
        step(1'b0, 32'd0, 32'd0);
        step(1'b0, 32'd0, 32'd0);
        chk("str_acc_w", w_acc, 72);
        chk("str_acc_s", s_acc, 72);
        chk("str_cnt",   w_cnt, 8);
        chk("str_ovf",   w_ovf, 0);
        chk("str_busy",  s_busy, 0);

        // Sum overflow: SMAX*1 then 1*1
        do_reset();
        step(1'b1, SMAX, 32'd1);
        step(1'b1, 32'd1, 32'd1);
        step(1'b0, 32'd0, 32'd0);
        step(1'b0, 32'd0, 32'd0);
        chk("sov_acc_w", w_acc, 32'h8000_0000);
        chk("sov_ovf_w", w_ovf, 1);
        chk("sov_acc_s", s_acc, 32'h7FFF_FFFF);
        chk("sov_ovf_s", s_ovf, 1);

        // Product overflow: 2^16 * 2^16, then -1 moves clamp off the rail
        do_reset();
        step(1'b1, 32'h0001_0000, 32'h0001_0000);
        step(1'b0, 32'd0, 32'd0);
        step(1'b0, 32'd0, 32'd0);
        chk("pov_acc_w", w_acc, 0);
        chk("pov_ovf_w", w_ovf, 1);
        chk("pov_acc_s", s_acc, 32'h7FFF_FFFF);
        chk("pov_ovf_s", s_ovf, 1);
        step(1'b1, 32'hFFFF_FFFF, 32'd1);
        step(1'b0, 32'd0, 32'd0);
        step(1'b0, 32'd0, 32'd0);
        chk("rail_acc_s", s_acc, 32'h7FFF_FFFE);
        chk("rail_ovf_s", s_ovf, 1);
        chk("rail_acc_w", w_acc, 32'hFFFF_FFFF);

        // Reset mid-stream, i_run held high through reset
        do_reset();
        step(1'b1, 32'd1, 32'd1);
        step(1'b1, 32'd1, 32'd1);
        chk("mid_acc_pre", w_acc, 1);
        i_run   = 1'b1;
        m_rst_t = 1'b1;
        #1;
        chk("mid_acc_async",  w_acc,  0);
        chk("mid_cnt_async",  w_cnt,  0);
        chk("mid_busy_async", w_busy, 0);
        step(1'b1, 32'd7, 32'd7);
        chk("rsthold_acc",  w_acc,  0);
        chk("rsthold_busy", s_busy, 0);
        m_rst_t = 1'b0;
        step(1'b0, 32'd0, 32'd0);
        chk("rsthold_busy2", w_busy, 0);
        chk("rsthold_acc2",  s_acc,  0);
        step(1'b1, 32'd5, 32'hFFFF_FFFD);
        step(1'b0, 32'd0, 32'd0);
        step(1'b0, 32'd0, 32'd0);
        chk("neg_acc_w", w_acc, 32'hFFFF_FFF1);
        chk("neg_acc_s", s_acc, 32'hFFFF_FFF1);
        chk("neg_cnt",   w_cnt, 1);

        // Gapped pattern 1,0,1,0,1 of 2*2
        do_reset();
        step(1'b1, 32'd2, 32'd2);
        step(1'b0, 32'd2, 32'd2);
        step(1'b1, 32'd2, 32'd2);
        step(1'b0, 32'd2, 32'd2);
        step(1'b1, 32'd2, 32'd2);
        step(1'b0, 32'd0, 32'd0);
        step(1'b0, 32'd0, 32'd0);
        chk("gap_acc", w_acc, 12);
        chk("gap_cnt", s_cnt, 3);

        // Counter saturates at all-ones
        do_reset();
        for (int k = 0; k < 260; k++) step(1'b1, 32'd0, 32'd0);
        step(1'b0, 32'd0, 32'd0);
        step(1'b0, 32'd0, 32'd0);
        chk("cnt_sat_w", w_cnt, 255);
        chk("cnt_sat_s", s_cnt, 255);
        chk("cnt_sat_acc", w_acc, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/matrix_mac_pipe.md
# matrix_mac_pipe

Two-stage pipelined signed multiply-accumulate engine for the matrix accelerator. It sits between the operand memories and the result memory of the Wishbone matrix peripheral. Each cycle it consumes one operand pair addressed by the sequencing FSM, and it accumulates one dot-product term per valid cycle. The running sum feeds the third-matrix write path. A pulse on m_rst_t clears the block between result elements.

## Interface
- DATA_W, 32: operand and accumulator width, signed two's complement.
- CNT_W, 8: width of the term counter.
- SATURATE, 0: 0 wraps modulo 2^DATA_W; 1 clamps to the signed limits.

Ports:
- i_wb_clk  in  1  clock; all state advances on posedge.
- m_rst_t  in  1  reset m_rst_t, asynchronous, active-high; clock i_wb_clk.
- i_run  in  1  operand pair on i_a/i_b is valid this cycle.
- i_a  in  DATA_W  first-matrix element, signed.
- i_b  in  DATA_W  second-matrix element, signed.
- o_acc  out  DATA_W  accumulated sum, registered.
- o_busy  out  1  at least one term is in flight (stage-1 or stage-2 valid).
- o_count  out  CNT_W  number of terms accumulated since reset.
- o_ovf  out  1  sticky: a product or sum exceeded the signed DATA_W range.

## Operation
- Stage 1 (S1), on posedge with i_run=1:
  - p1 <= signed(i_a)*signed(i_b), computed at full 2*DATA_W.
  - Then reduced to DATA_W: truncated if SATURATE=0, clamped if SATURATE=1.
  - v1 <= 1.
  - ovf1 <= the full product lies outside [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- S1, on posedge with i_run=0: v1 <= 0; p1 holds its value.
- Stage 2 (S2), on posedge with v1=1:
  - o_acc <= o_acc + p1. Signed overflow wraps or clamps per SATURATE.
  - o_count <= o_count+1. The counter saturates at all-ones and does not wrap.
  - o_ovf <= o_ovf | ovf1 | add_overflow.
- S2, on posedge with v1=0: o_acc, o_count and o_ovf hold.
- Add overflow detect: the operands have equal signs and the result sign differs.
- Clamp values: positive overflow gives 2^(DATA_W-1)-1; negative overflow gives -2^(DATA_W-1).
- o_busy = v1 | v2, where v2 is a registered copy of v1. v2 marks that the S2 output was updated in the last cycle.
- There is no backpressure. Every i_run cycle is accepted.

## Timing
- Latency: an operand pair presented at posedge N appears in o_acc after posedge N+2.
- Throughput: one term per cycle.
- Drain rule: upstream must hold i_run=0 for at least 2 cycles before asserting m_rst_t. o_busy=0 indicates the sum is complete and stable.
- Reset values: p1=0, v1=0, v2=0, o_acc=0, o_count=0, o_ovf=0, o_busy=0.
- Reset asserts asynchronously, so outputs clear immediately. A consumer must capture o_acc before or at the m_rst_t rising edge.
- Reset deassertion is sampled at the next posedge. The first term may be presented on the first posedge after deassertion.
- Reset mid-operation: all in-flight terms are discarded and the partial sum is lost. No output glitches beyond the transition to 0.
- i_run=1 while m_rst_t=1: the operand pair is ignored.
- Back-to-back terms with interleaved idle cycles: the sum is unaffected by gaps.
- SATURATE=1: once clamped, the accumulator may move back off the rail by later opposite-sign terms. o_ovf stays 1.

## Structure
- Shared package matrix_pkg holds:
  - DATA_W and CNT_W defaults.
  - Signed limit constants SMAX and SMIN.
  - The SATURATE encoding, shared with the FSM and top.
- Natural sub-module: matrix_sat_add.
  - Combinational signed DATA_W adder with overflow flag.
  - Optional clamp selected by parameter.
  - Reused by S2.

## Test plan
- Reset, then i_run=1 for 1 cycle with a=3, b=4 -> o_acc=12 two posedges later; o_count=1; o_busy high for 2 cycles, then low.
- Stream a={1..8}, b=2, then idle -> o_acc=72, o_count=8, o_ovf=0.
- With SATURATE=0, feed 0x7FFFFFFF*1 then 1*1 -> o_acc=0x80000000, o_ovf=1. With SATURATE=1, the same stimulus -> o_acc=0x7FFFFFFF, o_ovf=1.
- Product overflow: a=0x10000, b=0x10000 -> SATURATE=0 gives o_acc=0, o_ovf=1; SATURATE=1 gives 0x7FFFFFFF.
- Assert m_rst_t one cycle after 4 terms start -> o_acc=0, o_count=0, o_busy=0 immediately. After release, a=5, b=-3 gives o_acc=-15.
- Pattern i_run=1,0,1,0,1 with a=b=2 -> o_acc=12, o_count=3. i_run held high during reset -> no accumulation.
